// File: rtl/swd_target_responder.sv
// SWD target responder: decodes host requests on an oversampled swclk, answers ACK/read data and
// commits parity-checked writes into an 8x32 bank. Define SWD_TGT_STATS_EN for transaction counters.
module swd_target_responder #(
    parameter logic [31:0] IDCODE         = 32'h0BC1_1477,
    parameter int unsigned LINE_RESET_LEN = 50
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        swclk,
    input  logic        swdio_in,
    output logic        swdio_out,
    output logic        swdio_oe,
    input  logic [2:0]  ack_sel,
    output logic        proto_err,
    output logic        wpar_err,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic [31:0] wr_data
`ifdef SWD_TGT_STATS_EN
    ,
    output logic [15:0] ok_cnt,
    output logic [15:0] wait_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, TRN, ACK, RDATA, WDATA, NACK} state_t;

    localparam int LR_W = $clog2(LINE_RESET_LEN + 1);
    localparam logic [LR_W-1:0] LR_MAX = LR_W'(LINE_RESET_LEN);

    // Request bits LSB-first: start, APnDP, RnW, A2, A3, parity, stop, park
    function automatic logic req_ok(input logic [7:0] r);
        return r[0] && !r[6] && r[7] && (r[5] == ^r[4:1]);
    endfunction

    logic        clk_s1_q, clk_s2_q, clk_s3_q, dio_s1_q, dio_s2_q;
    logic        rise, bit_in;
    state_t      state_q, state_d;
    logic [5:0]  n_q, n_d;
    logic [7:0]  req_q, req_d;
    logic [2:0]  ack_q, ack_d;
    logic [31:0] rd_q, rd_d, wd_q, wd_d;
    logic        rpar_q, rpar_d;
    logic [LR_W-1:0] lr_q, lr_d;
    logic        last_q, last_d;
    logic        out_q, out_d, oe_q, oe_d;
    logic        proto_q, proto_d, wpar_q, wpar_d;
    logic        strobe_q, strobe_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] bank_q [8];
    logic [31:0] bank_d [8];
    logic [2:0]  addr;
    logic        dp0;

    assign rise   = clk_s2_q & ~clk_s3_q;
    assign bit_in = dio_s2_q;
    assign addr   = {req_q[1], req_q[4], req_q[3]};
    assign dp0    = (addr == 3'b000);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        req_d     = req_q;
        ack_d     = ack_q;
        rd_d      = rd_q;
        rpar_d    = rpar_q;
        wd_d      = wd_q;
        lr_d      = lr_q;
        last_d    = last_q;
        out_d     = out_q;
        oe_d      = oe_q;
        proto_d   = proto_q;
        wpar_d    = wpar_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bank_d    = bank_q;
        if (rise) begin
            last_d = bit_in;
            // The target owns the line during ACK and read data, so those bits never count
            if (state_q == ACK || state_q == RDATA || !bit_in) lr_d = '0;
            else if (lr_q != LR_MAX) lr_d = lr_q + 1'b1;
            n_d = n_q + 6'd1;
            case (state_q)
                IDLE: begin
                    n_d = n_q;
                    if (bit_in && !last_q) begin
                        state_d = REQ;
                        n_d     = 6'd1;
                        req_d   = 8'h01;
                    end
                end
                REQ: begin
                    req_d[n_q[2:0]] = bit_in;
                    if (n_q == 6'd7) begin
                        if (req_ok(req_d)) state_d = TRN;
                        else begin
                            state_d = IDLE;
                            n_d     = '0;
                            proto_d = 1'b1;
                        end
                    end
                end
                TRN: begin
                    ack_d   = ack_sel;
                    rd_d    = dp0 ? IDCODE : bank_q[addr];
                    rpar_d  = ^rd_d;
                    state_d = ACK;
                end
                ACK: begin
                    oe_d = 1'b1;
                    case (n_q)
                        6'd9:    out_d = ack_q[0];
                        6'd10:   out_d = ack_q[1];
                        default: out_d = ack_q[2];
                    endcase
                    if (n_q == 6'd11) begin
                        if (ack_q != 3'b001) state_d = NACK;
                        else state_d = req_q[2] ? RDATA : WDATA;
                    end
                end
                NACK: begin
                    oe_d    = 1'b0;
                    out_d   = 1'b1;
                    state_d = IDLE;
                    n_d     = '0;
                end
                RDATA: begin
                    if (n_q <= 6'd43) begin
                        out_d = rd_q[0];
                        rd_d  = {1'b0, rd_q[31:1]};
                    end else if (n_q == 6'd44) begin
                        out_d = rpar_q;
                    end else begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = IDLE;
                        n_d     = '0;
                    end
                end
                WDATA: begin
                    if (n_q == 6'd12) begin
                        oe_d  = 1'b0;
                        out_d = 1'b1;
                    end else if (n_q <= 6'd44) begin
                        wd_d = {bit_in, wd_q[31:1]};
                    end else begin
                        state_d = IDLE;
                        n_d     = '0;
                        if (bit_in != ^wd_q) wpar_d = 1'b1;
                        else if (!dp0) begin
                            bank_d[addr] = wd_q;
                            strobe_d     = 1'b1;
                            wr_addr_d    = addr;
                            wr_data_d    = wd_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (lr_d == LR_MAX) begin
                state_d = IDLE;
                n_d     = '0;
                oe_d    = 1'b0;
                out_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_s3_q  <= 1'b0;
            dio_s1_q  <= 1'b0;
            dio_s2_q  <= 1'b0;
            state_q   <= IDLE;
            n_q       <= '0;
            req_q     <= '0;
            ack_q     <= '0;
            rd_q      <= '0;
            rpar_q    <= 1'b0;
            wd_q      <= '0;
            lr_q      <= '0;
            last_q    <= 1'b1;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            proto_q   <= 1'b0;
            wpar_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
        end else begin
            clk_s1_q  <= swclk;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            dio_s1_q  <= swdio_in;
            dio_s2_q  <= dio_s1_q;
            state_q   <= state_d;
            n_q       <= n_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            rd_q      <= rd_d;
            rpar_q    <= rpar_d;
            wd_q      <= wd_d;
            lr_q      <= lr_d;
            last_q    <= last_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            proto_q   <= proto_d;
            wpar_q    <= wpar_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bank_q    <= bank_d;
        end
    end

    assign swdio_out = out_q;
    assign swdio_oe  = oe_q;
    assign proto_err = proto_q;
    assign wpar_err  = wpar_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

`ifdef SWD_TGT_STATS_EN
    logic [15:0] ok_cnt_q, wait_cnt_q, err_cnt_q;
    logic        ok_evt, wait_evt, err_evt;

    always_comb begin
        ok_evt   = rise && n_q == 6'd45 &&
                   (state_q == RDATA || (state_q == WDATA && bit_in == ^wd_q));
        wait_evt = rise && state_q == NACK;
        err_evt  = rise && ((state_q == REQ && n_q == 6'd7 && !req_ok(req_d)) ||
                            (state_q == WDATA && n_q == 6'd45 && bit_in != ^wd_q));
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            ok_cnt_q   <= '0;
            wait_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            ok_cnt_q   <= ok_cnt_q + {15'd0, ok_evt};
            wait_cnt_q <= wait_cnt_q + {15'd0, wait_evt};
            err_cnt_q  <= err_cnt_q + {15'd0, err_evt};
        end
    end

    assign ok_cnt   = ok_cnt_q;
    assign wait_cnt = wait_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_swd_target_responder.sv
// Scoreboard bench for swd_target_responder: a host task drives frames and queues the expected
// line response per swclk bit and per committed write; independent monitors pop and compare.
module tb_swd_target_responder;

    localparam logic [31:0] IDCODE_M = 32'h0BC1_1477;

    typedef struct packed {
        logic [7:0] n;
        logic       oe;
        logic       out;
        logic       chk;
    } bit_exp_t;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        swclk = 1'b0;
    logic        host_drv = 1'b0;
    logic        swdio_in;
    logic        swdio_out, swdio_oe;
    logic [2:0]  ack_sel = 3'b001;
    logic        proto_err, wpar_err, wr_strobe;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    int tests = 0;
    int fails = 0;

    bit_exp_t    bit_q[$];
    logic [34:0] wr_q[$];
    logic [31:0] bank_m [8];
    logic        m_proto = 1'b0;
    logic        m_wpar = 1'b0;

    assign swdio_in = swdio_oe ? swdio_out : host_drv;

    swd_target_responder dut (
        .sck(sck), .rst(rst), .swclk(swclk), .swdio_in(swdio_in),
        .swdio_out(swdio_out), .swdio_oe(swdio_oe), .ack_sel(ack_sel),
        .proto_err(proto_err), .wpar_err(wpar_err), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 sck = ~sck;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: one expectation per swclk rise, sampled well after the target's update
    initial begin
        bit_exp_t e;
        forever begin
            @(posedge swclk);
            #60;
            if (bit_q.size() == 0) begin
                check("bit_queue_underrun", 35'd1, 35'd0);
            end else begin
                e = bit_q.pop_front();
                check($sformatf("swdio_oe n=%0d", e.n), {34'd0, swdio_oe}, {34'd0, e.oe});
                if (e.chk) check($sformatf("swdio_out n=%0d", e.n), {34'd0, swdio_out}, {34'd0, e.out});
            end
        end
    end

    // Write monitor: every strobe must match the oldest expected commit
    initial begin
        forever begin
            @(posedge sck);
            #1;
            if (wr_strobe) begin
                if (wr_q.size() == 0) check("unexpected_wr_strobe", {wr_addr, wr_data}, 35'd0);
                else check("wr_commit", {wr_addr, wr_data}, wr_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_bit(input logic v, input logic eoe, input logic eout, input logic chk, input int n);
        bit_exp_t e;
        e.n   = n[7:0];
        e.oe  = eoe;
        e.out = eout;
        e.chk = chk;
        host_drv = v;
        bit_q.push_back(e);
        #40 swclk = 1'b1;
        #40 swclk = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) clk_bit(1'b0, 1'b0, 1'b1, 1'b0, 99);
    endtask

    // One host transaction; the expected target behaviour comes from the protocol rules and bank_m
    task automatic frame(input logic ap, input logic rnw, input logic [1:0] a, input logic [31:0] wdat,
                         input logic [2:0] ack, input logic bad_rpar, input logic bad_wpar, input int stop_at);
        logic [7:0]  req;
        logic [2:0]  idx;
        logic [31:0] rdat;
        idx    = {ap, a[1], a[0]};
        req[0] = 1'b1;
        req[1] = ap;
        req[2] = rnw;
        req[3] = a[0];
        req[4] = a[1];
        req[5] = ap ^ rnw ^ a[0] ^ a[1] ^ bad_rpar;
        req[6] = 1'b0;
        req[7] = 1'b1;
        ack_sel = ack;
        for (int n = 0; n < 8; n++) clk_bit(req[n], 1'b0, 1'b1, 1'b0, n);
        if (bad_rpar) begin
            m_proto = 1'b1;
            for (int n = 8; n < 46; n++) clk_bit(1'b0, 1'b0, 1'b1, 1'b0, n);
            idle(2);
            return;
        end
        clk_bit(1'b0, 1'b0, 1'b1, 1'b0, 8);
        for (int n = 9; n < 12; n++) clk_bit(1'b0, 1'b1, ack[n-9], 1'b1, n);
        if (ack != 3'b001) begin
            clk_bit(1'b0, 1'b0, 1'b1, 1'b0, 12);
            idle(2);
            return;
        end
        if (rnw) begin
            rdat = (idx == 3'b000) ? IDCODE_M : bank_m[idx];
            for (int n = 12; n < 44; n++) begin
                if (n == stop_at) return;
                clk_bit(1'b0, 1'b1, rdat[n-12], 1'b1, n);
            end
            clk_bit(1'b0, 1'b1, ^rdat, 1'b1, 44);
            clk_bit(1'b0, 1'b0, 1'b1, 1'b0, 45);
        end else begin
            clk_bit(1'b0, 1'b0, 1'b1, 1'b0, 12);
            for (int n = 13; n < 45; n++) clk_bit(wdat[n-13], 1'b0, 1'b1, 1'b0, n);
            if (bad_wpar) m_wpar = 1'b1;
            else if (idx != 3'b000) begin
                bank_m[idx] = wdat;
                wr_q.push_back({idx, wdat});
            end
            clk_bit((^wdat) ^ bad_wpar, 1'b0, 1'b1, 1'b0, 45);
        end
        idle(2);
    endtask

    task automatic check_flags(input string tag);
        check({tag, " proto_err"}, {34'd0, proto_err}, {34'd0, m_proto});
        check({tag, " wpar_err"}, {34'd0, wpar_err}, {34'd0, m_wpar});
    endtask

    initial begin
        logic [2:0] ack;
        logic       ap, rnw;
        logic [1:0] a;
        int         r;
        for (int i = 0; i < 8; i++) bank_m[i] = '0;

        repeat (5) @(posedge sck);
        #1;
        check("reset swdio_oe", {34'd0, swdio_oe}, 35'd0);
        check("reset swdio_out", {34'd0, swdio_out}, 35'd1);
        check("reset wr_strobe", {34'd0, wr_strobe}, 35'd0);
        check("reset wr_addr_data", {wr_addr, wr_data}, 35'd0);
        check_flags("reset");
        @(negedge sck) rst = 1'b0;

        for (int i = 0; i < 52; i++) clk_bit(1'b1, 1'b0, 1'b1, 1'b0, 98);
        idle(2);
        check_flags("line_reset");

        frame(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b0, 2'b01, 32'h1234_5678, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b01, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b01, 32'h0, 3'b010, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b01, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b0, 1'b1, 2'b10, 32'h0, 3'b001, 1'b1, 1'b0, -1);
        check_flags("bad_req_parity");
        frame(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b0, 2'b01, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, -1);
        check_flags("bad_wdata_parity");
        frame(1'b1, 1'b1, 2'b01, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b0, 1'b0, 2'b00, 32'hCAFE_F00D, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b11, 32'h0, 3'b100, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            ap  = 1'($urandom_range(0, 1));
            rnw = 1'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 3));
            r   = int'($urandom_range(0, 5));
            ack = (r <= 2) ? 3'b001 : (r == 3) ? 3'b010 : (r == 4) ? 3'b100 : 3'($urandom_range(0, 7));
            frame(ap, rnw, a, $urandom, ack, 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 7) == 0), -1);
            check_flags("random");
        end

        m_proto = 1'b1;
        m_wpar  = 1'b1;
        frame(1'b1, 1'b0, 2'b10, 32'h0, 3'b001, 1'b0, 1'b1, -1);
        frame(1'b0, 1'b1, 2'b11, 32'h0, 3'b001, 1'b1, 1'b0, -1);
        frame(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 1'b0, 1'b0, 21);
        #30;
        @(negedge sck) rst = 1'b1;
        @(posedge sck);
        #1;
        check("midframe_rst swdio_oe", {34'd0, swdio_oe}, 35'd0);
        check("midframe_rst swdio_out", {34'd0, swdio_out}, 35'd1);
        m_proto = 1'b0;
        m_wpar  = 1'b0;
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        check_flags("midframe_rst");
        check("midframe_rst line_queue_drained", 35'(bit_q.size()), 35'd0);
        repeat (2) @(posedge sck);
        @(negedge sck) rst = 1'b0;
        idle(2);
        frame(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b01, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b0, 2'b11, 32'h89AB_CDEF, 3'b001, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b1, 2'b11, 32'h0, 3'b001, 1'b0, 1'b0, -1);
        check_flags("after_rst");

        #200;
        check("write_queue_drained", 35'(wr_q.size()), 35'd0);
        check("line_queue_empty", 35'(bit_q.size()), 35'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
